// File: rtl/vtg_pkg.sv
// ----------------------------------------------------------------------------
// vtg_pkg
// Shared definitions for the video timing generator family: FSM state
// encoding and helpers that derive line/frame totals and sync windows from
// the porch/pulse parameters. Kept free of module parameters so scoreboards
// and multi-mode variants can call the same helpers.
// ----------------------------------------------------------------------------
package vtg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } vtg_state_e;

  localparam int VTG_MAX_LATENCY = 15;

  // Total clocks per line (or lines per frame) for one axis.
  function automatic int vtg_total(input int res, input int fp, input int pw, input int bp);
    return res + fp + pw + bp;
  endfunction

  // First count inside the sync pulse.
  function automatic int vtg_sync_beg(input int res, input int fp);
    return res + fp;
  endfunction

  // First count after the sync pulse (exclusive bound).
  function automatic int vtg_sync_end(input int res, input int fp, input int pw);
    return res + fp + pw;
  endfunction

endpackage

// File: rtl/vtg_delay_line.sv
// ----------------------------------------------------------------------------
// vtg_delay_line
// WIDTH x DEPTH shift register used to align decoded timing signals with
// pixel data read latency. DEPTH = 0 is a pure combinational pass-through.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   i_rst_val  in   value every stage takes during reset
//   i_d        in   data into stage 0
//   o_q        out  data out of the last stage (or i_d when DEPTH = 0)
// ----------------------------------------------------------------------------
module vtg_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pipe [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_pipe[i] <= i_rst_val;
        end else begin
          r_pipe[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
// Parametrised raster timing generator. Produces h/v counters, active and
// sync strobes (delayed by LATENCY to match pixel read latency), a line
// preload request and a frame-start pulse. Start/stop at runtime via en;
// a stop request always lets the current frame finish.
//
// Optional feature macro: VTG_FRAME_COUNTER_EN adds a 16-bit frame_cnt output.
//
// Ports:
//   clk               in   pixel clock
//   reset_n           in   asynchronous active-low reset
//   en                in   run request (level)
//   hpos, vpos        out  current horizontal / vertical count (undelayed)
//   active            out  active pixel, delayed LATENCY
//   h_sync, v_sync    out  syncs at configured polarity, delayed LATENCY
//   preload_vid_line  out  one-cycle request to fetch the next active line
//   frame_start       out  one-cycle pulse at (0,0) while running
//   running           out  FSM not in IDLE
//   frame_cnt         out  frames since first start (macro-enabled only)
//
// State | meaning
// IDLE  | counters held at 0, decode forced inactive
// RUN   | counting, en high
// STOP  | counting, en low; drops to IDLE at the last pixel of the frame
// ----------------------------------------------------------------------------
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int   CNT_W      = 11,
  parameter int   H_RES_PIX  = 640,
  parameter int   H_FN_PRCH  = 32,
  parameter int   H_SYNC_PW  = 88,
  parameter int   H_BK_PRCH  = 32,
  parameter int   V_RES_PIX  = 480,
  parameter int   V_FN_PRCH  = 10,
  parameter int   V_SYNC_PW  = 5,
  parameter int   V_BK_PRCH  = 10,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   LATENCY    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             active,
  output logic             h_sync,
  output logic             v_sync,
  output logic             preload_vid_line,
  output logic             frame_start,
`ifdef VTG_FRAME_COUNTER_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             running
);

  localparam int H_TOTAL = vtg_total(H_RES_PIX, H_FN_PRCH, H_SYNC_PW, H_BK_PRCH);
  localparam int V_TOTAL = vtg_total(V_RES_PIX, V_FN_PRCH, V_SYNC_PW, V_BK_PRCH);

  generate
    if (H_TOTAL >= (64'd1 << CNT_W)) begin : g_h_chk
      $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL >= (64'd1 << CNT_W)) begin : g_v_chk
      $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if (LATENCY < 0 || LATENCY > VTG_MAX_LATENCY) begin : g_lat_chk
      $error("video_timing_gen: LATENCY out of range 0..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] L_ZERO   = '0;
  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_H_RES  = CNT_W'(H_RES_PIX);
  localparam logic [CNT_W-1:0] L_V_RES  = CNT_W'(V_RES_PIX);
  localparam logic [CNT_W-1:0] L_HS_BEG = CNT_W'(vtg_sync_beg(H_RES_PIX, H_FN_PRCH));
  localparam logic [CNT_W-1:0] L_HS_END = CNT_W'(vtg_sync_end(H_RES_PIX, H_FN_PRCH, H_SYNC_PW));
  localparam logic [CNT_W-1:0] L_VS_BEG = CNT_W'(vtg_sync_beg(V_RES_PIX, V_FN_PRCH));
  localparam logic [CNT_W-1:0] L_VS_END = CNT_W'(vtg_sync_end(V_RES_PIX, V_FN_PRCH, V_SYNC_PW));

  // {act, hs, vs} as seen while idle / in reset
  localparam logic [2:0] L_RAW_IDLE = {1'b0, ~H_SYNC_POL, ~V_SYNC_POL};

  vtg_state_e       r_state;
  vtg_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_hpos;
  logic [CNT_W-1:0] r_vpos;
  logic [CNT_W-1:0] w_vpos_next_line;
  logic             w_running;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_frame_end;
  logic             w_act;
  logic             w_hs;
  logic             w_vs;
  logic [2:0]       w_dly;

  assign w_h_last    = (r_hpos == L_H_LAST);
  assign w_v_last    = (r_vpos == L_V_LAST);
  assign w_frame_end = w_h_last && w_v_last;
  assign w_vpos_next_line = w_v_last ? L_ZERO : (r_vpos + L_ONE);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state. STOP re-entering RUN keeps the counters untouched.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en) w_state_nxt = ST_RUN;
      ST_RUN:  if (!en) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (en)               w_state_nxt = ST_RUN;
        else if (w_frame_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. Strobes are decoded from registered state and counters,
  // so an asynchronous reset clears them immediately.
  always_comb begin
    w_running        = (r_state != ST_IDLE);
    frame_start      = w_running && (r_hpos == L_ZERO) && (r_vpos == L_ZERO);
    preload_vid_line = w_running && (r_hpos == L_H_RES) && (w_vpos_next_line < L_V_RES);
  end

  // Counters; leaving STOP at the frame end wraps to (0,0) naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hpos <= L_ZERO;
      r_vpos <= L_ZERO;
    end else if (!w_running) begin
      r_hpos <= L_ZERO;
      r_vpos <= L_ZERO;
    end else if (w_h_last) begin
      r_hpos <= L_ZERO;
      r_vpos <= w_vpos_next_line;
    end else begin
      r_hpos <= r_hpos + L_ONE;
    end
  end

  // Undelayed decode; forced inactive while idle so (0,0) does not look active.
  always_comb begin
    w_act = w_running && (r_hpos < L_H_RES) && (r_vpos < L_V_RES);
    w_hs  = (w_running && (r_hpos >= L_HS_BEG) && (r_hpos < L_HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    w_vs  = (w_running && (r_vpos >= L_VS_BEG) && (r_vpos < L_VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  vtg_delay_line #(
    .WIDTH (3),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_rst_val (L_RAW_IDLE),
    .i_d       ({w_act, w_hs, w_vs}),
    .o_q       (w_dly)
  );

  assign active  = w_dly[2];
  assign h_sync  = w_dly[1];
  assign v_sync  = w_dly[0];
  assign hpos    = r_hpos;
  assign vpos    = r_vpos;
  assign running = w_running;

`ifdef VTG_FRAME_COUNTER_EN
  // Bumps on the wrap into (0,0) that stays running, so the first
  // frame_start after IDLE shows the held value and later ones show +1.
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_frame_cnt <= 16'd0;
    else if (w_running && w_frame_end && (w_state_nxt != ST_IDLE))
      r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_video_timing_gen
// Scoreboard bench for video_timing_gen in a small mode (H 8/2/3/1, V 4/1/2/1,
// LATENCY 2). The reference model tracks the position inside the frame as a
// single pixel index and derives every output from it arithmetically. A
// second instance with positive polarity exercises asynchronous reset.
// ----------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int CW  = 11;
  localparam int HR  = 8, HF = 2, HS = 3, HB = 1;
  localparam int VR  = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT  = HR + HF + HS + HB;   // 14
  localparam int VT  = VR + VF + VS + VB;   // 8
  localparam int FR  = HT * VT;             // 112
  localparam int LAT = 2;
  localparam bit HPOL = 1'b0, VPOL = 1'b0;

  typedef struct {
    int h; int v;
    bit act; bit hs; bit vs;
    bit pre; bit fs; bit run;
    int fc;
  } exp_t;

  logic clk, rst_n, en, rst2_n, en2;

  logic [CW-1:0] hpos, vpos, hpos2, vpos2;
  logic active, h_sync, v_sync, pre, fs, running;
  logic active2, h_sync2, v_sync2, pre2, fs2, running2;
`ifdef VTG_FRAME_COUNTER_EN
  logic [15:0] frame_cnt, frame_cnt2;
`endif

  video_timing_gen #(
    .CNT_W(CW), .H_RES_PIX(HR), .H_FN_PRCH(HF), .H_SYNC_PW(HS), .H_BK_PRCH(HB),
    .V_RES_PIX(VR), .V_FN_PRCH(VF), .V_SYNC_PW(VS), .V_BK_PRCH(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(rst_n), .en(en), .hpos(hpos), .vpos(vpos),
    .active(active), .h_sync(h_sync), .v_sync(v_sync),
    .preload_vid_line(pre), .frame_start(fs),
`ifdef VTG_FRAME_COUNTER_EN
    .frame_cnt(frame_cnt),
`endif
    .running(running)
  );

  video_timing_gen #(
    .CNT_W(CW), .H_RES_PIX(HR), .H_FN_PRCH(HF), .H_SYNC_PW(HS), .H_BK_PRCH(HB),
    .V_RES_PIX(VR), .V_FN_PRCH(VF), .V_SYNC_PW(VS), .V_BK_PRCH(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LATENCY(LAT)
  ) dut2 (
    .clk(clk), .reset_n(rst2_n), .en(en2), .hpos(hpos2), .vpos(vpos2),
    .active(active2), .h_sync(h_sync2), .v_sync(v_sync2),
    .preload_vid_line(pre2), .frame_start(fs2),
`ifdef VTG_FRAME_COUNTER_EN
    .frame_cnt(frame_cnt2),
`endif
    .running(running2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  exp_t q[$];

  // Reference model: m_p is the pixel index within the frame while live.
  bit       m_live, m_stop;
  int       m_p, m_fc;
  bit [2:0] m_hist [0:15];

  function automatic bit [2:0] raw_idle();
    return {1'b0, ~HPOL, ~VPOL};
  endfunction

  task automatic model_reset();
    m_live = 0; m_stop = 0; m_p = 0; m_fc = 0;
    for (int i = 0; i < 16; i++) m_hist[i] = raw_idle();
  endtask

  // One clock edge of the model, given the en/rst_n values the DUT sampled.
  task automatic model_step(input bit en_s, input bit rst_s);
    exp_t e;
    bit a, hsa, vsa;
    int h, v;
    if (!rst_s) begin
      model_reset();
    end else if (!m_live) begin
      if (en_s) begin m_live = 1; m_stop = 0; m_p = 0; end
    end else if (m_p == FR - 1 && m_stop && !en_s) begin
      m_live = 0; m_p = 0;
    end else begin
      if (m_p == FR - 1) m_fc = (m_fc + 1) % 65536;
      m_p = (m_p + 1) % FR;
      m_stop = !en_s;
    end
    h = m_live ? m_p % HT : 0;
    v = m_live ? m_p / HT : 0;
    a   = m_live && h < HR && v < VR;
    hsa = m_live && h >= HR + HF && h < HR + HF + HS;
    vsa = m_live && v >= VR + VF && v < VR + VF + VS;
    if (rst_s) begin
      for (int i = 15; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = {a, hsa ? HPOL : ~HPOL, vsa ? VPOL : ~VPOL};
    end
    e.h = h; e.v = v;
    e.act = m_hist[LAT][2]; e.hs = m_hist[LAT][1]; e.vs = m_hist[LAT][0];
    e.pre = m_live && h == HR && ((v + 1) % VT) < VR;
    e.fs  = m_live && m_p == 0;
    e.run = m_live;
    e.fc  = m_fc;
    q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(en, rst_n);
  endtask

  task automatic check(input string name, input int act_v, input int exp_v);
    n_vec++;
    if (act_v != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic run_to(input int h, input int v, input string name);
    int k;
    k = 0;
    while (!(m_live && m_p == v * HT + h) && k < 4 * FR) begin
      cycle();
      k++;
    end
    if (k >= 4 * FR) timeout_fail(name);
  endtask

  // Monitor: compares one scoreboard entry per clock on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    bit bad;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      bad = (int'(hpos) != e.h) || (int'(vpos) != e.v) || (active != e.act) ||
            (h_sync != e.hs) || (v_sync != e.vs) || (pre != e.pre) ||
            (fs != e.fs) || (running != e.run);
`ifdef VTG_FRAME_COUNTER_EN
      bad = bad || (int'(frame_cnt) != e.fc);
`endif
      if (bad) begin
        n_err++;
        $display("FAIL scoreboard @%0t: got h=%0d v=%0d act=%0b hs=%0b vs=%0b pre=%0b fs=%0b run=%0b, expected h=%0d v=%0d act=%0b hs=%0b vs=%0b pre=%0b fs=%0b run=%0b fc=%0d",
                 $time, hpos, vpos, active, h_sync, v_sync, pre, fs, running,
                 e.h, e.v, e.act, e.hs, e.vs, e.pre, e.fs, e.run, e.fc);
      end
    end
  end

  initial begin
    int k, len;
    rst_n = 0; en = 0; rst2_n = 0; en2 = 0;
    model_reset();

    // Reset values held for a few cycles, then three full frames with en=1.
    repeat (3) cycle();
    rst_n = 1;
    cycle();
    en = 1;
    repeat (3 * FR + 4) cycle();

    // Stop request at (3,2): frame completes, then IDLE.
    run_to(3, 2, "wait_stop_pos");
    en = 0;
    k = 0;
    while (m_live && k < 2 * FR) begin cycle(); k++; end
    if (m_live) timeout_fail("wait_idle");
    repeat (20) cycle();
    check("idle_running", running, 0);

    // Stop request withdrawn before the frame ends: no discontinuity.
    en = 1;
    repeat (5) cycle();
    run_to(3, 2, "wait_drop_pos");
    en = 0;
    run_to(5, 6, "wait_raise_pos");
    en = 1;
    repeat (2 * FR) cycle();

    // Positive-polarity instance: start, async reset mid-line, restart.
    rst2_n = 1; en2 = 1;
    cycle();
    check("p_fs_first", fs2, 1);
    check("p_hpos_first", int'(hpos2), 0);
    repeat (4) cycle();
    check("p_active_pre", active2, 1);
    check("p_hsync_pre", h_sync2, 0);
    #2 rst2_n = 0;
    #1;
    check("p_rst_active", active2, 0);
    check("p_rst_hsync", h_sync2, 0);
    check("p_rst_vsync", v_sync2, 0);
    check("p_rst_running", running2, 0);
    check("p_rst_hpos", int'(hpos2), 0);
    check("p_rst_fs", fs2, 0);
    cycle();
    rst2_n = 1;
    cycle();
    check("p_restart_fs", fs2, 1);
    cycle();
    check("p_restart_h1", int'(hpos2), 1);
    check("p_restart_fs_off", fs2, 0);

    // Randomised en segments.
    for (int s = 0; s < 16; s++) begin
      en  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 240);
      repeat (len) cycle();
    end

    // Asynchronous reset of the main instance mid-line.
    en = 1;
    run_to(5, 1, "wait_reset_pos");
    #2 rst_n = 0;
    q.delete();
    #1;
    check("rst_hpos", int'(hpos), 0);
    check("rst_vpos", int'(vpos), 0);
    check("rst_active", active, 0);
    check("rst_hsync", h_sync, 1);
    check("rst_vsync", v_sync, 1);
    check("rst_running", running, 0);
    check("rst_fs", fs, 0);
    repeat (2) cycle();
    rst_n = 1;
    repeat (FR + 20) cycle();
    en = 0;
    repeat (2 * FR + 10) cycle();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
